count60_ctrl: RTL and testbench

- Run/pause/clear controller for the 60-second counter on the Basys2 board.
- Takes the two raw push-buttons and the 50 MHz board clock, and sequences a two-digit BCD seconds count (00-59).
- Drives the 8-bit BCD bus consumed by the digit-scan/7-segment decoder.
- Generates the slow scan clock that the decoder runs on.

---
 rtl/count60_ctrl.sv | 128 ++++++++++++
 tb/tb_count60_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/count60_ctrl.sv
// count60_deb: 2-flop synchronizer + debounce, one-cycle pulse on accepted press
module count60_deb #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);
  localparam int DW = $clog2(DEB_CYCLES);
  logic s1_q, s2_q, lvl_q;
  logic [DW-1:0] cnt_q;
  // accept a new level only after it has been stable for DEB_CYCLES cycles
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      lvl_q   <= 1'b0;
      cnt_q   <= '0;
      press_o <= 1'b0;
    end else begin
      s1_q    <= btn_i;
      s2_q    <= s1_q;
      press_o <= 1'b0;
      if (s2_q == lvl_q) cnt_q <= '0;
      else if (cnt_q == DW'(DEB_CYCLES - 1)) begin
        lvl_q   <= s2_q;
        cnt_q   <= '0;
        press_o <= s2_q;
      end else cnt_q <= cnt_q + 1'b1;
    end
endmodule

// count60_ctrl: run/pause/clear controller for a 00-59 BCD seconds counter
module count60_ctrl #(
  parameter int TICK_DIV   = 50000000,
  parameter int SCAN_HALF  = 131579,
  parameter int DEB_CYCLES = 500000,
  parameter bit AUTO_STOP  = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_ss,
  input  logic       btn_clr,
  output logic [7:0] bcd,
  output logic       running,
  output logic       done,
  output logic       wrap,
  output logic       scan_clk
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_HALF + 1);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  state_t state_q;
  logic [TW-1:0] tdiv_q;
  logic [SW-1:0] scan_q;
  logic ss_p, clr_p, tick, at59, bad;
  logic [7:0] step_d;

  count60_deb #(.DEB_CYCLES(DEB_CYCLES)) u_ss  (.clk, .rst, .btn_i(btn_ss),  .press_o(ss_p));
  count60_deb #(.DEB_CYCLES(DEB_CYCLES)) u_clr (.clk, .rst, .btn_i(btn_clr), .press_o(clr_p));

  // count value after one step; illegal digits collapse to 00
  always_comb begin
    tick   = state_q == RUN && tdiv_q == TW'(TICK_DIV - 1);
    bad    = bcd[3:0] > 4'd9 || bcd[7:4] > 4'd5;
    at59   = bcd == 8'h59;
    step_d = bad || at59 ? 8'h00 :
             bcd[3:0] == 4'd9 ? {bcd[7:4] + 4'd1, 4'd0} : {bcd[7:4], bcd[3:0] + 4'd1};
  end

  // sequencing FSM with tick divider and registered outputs; clear beats start/stop
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      tdiv_q  <= '0;
      bcd     <= 8'h00;
      running <= 1'b0;
      done    <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (clr_p) begin
        state_q <= IDLE;
        tdiv_q  <= '0;
        bcd     <= 8'h00;
        running <= 1'b0;
        done    <= 1'b0;
      end else
        case (state_q)
          IDLE: if (ss_p) begin
            state_q <= RUN;
            tdiv_q  <= '0;
            running <= 1'b1;
          end
          RUN: begin
            tdiv_q <= tick ? '0 : tdiv_q + 1'b1;
            if (tick) begin
              bcd  <= at59 && AUTO_STOP ? bcd : step_d;
              wrap <= at59;
            end
            if (tick && at59 && AUTO_STOP) begin
              state_q <= DONE;
              running <= 1'b0;
              done    <= 1'b1;
            end else if (ss_p) begin
              state_q <= PAUSE;
              running <= 1'b0;
            end
          end
          PAUSE: if (ss_p) begin
            state_q <= RUN;
            running <= 1'b1;
          end
          default: ;
        endcase
    end

  // free-running scan clock, toggles every SCAN_HALF cycles
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      scan_q   <= '0;
      scan_clk <= 1'b0;
    end else if (scan_q == SW'(SCAN_HALF - 1)) begin
      scan_q   <= '0;
      scan_clk <= ~scan_clk;
    end else scan_q <= scan_q + 1'b1;
endmodule

// File: tb/tb_count60_ctrl.sv
// tb_count60_ctrl: directed bench with a bcd scoreboard for the seconds controller
module tb_count60_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic ss_a = 1'b0, clr_a = 1'b0, ss_b = 1'b0, clr_b = 1'b0;
  logic [7:0] bcd_a, bcd_b, prev_a = 8'h00, sb_exp;
  logic run_a, run_b, done_a, done_b, wrap_a, wrap_b, scan_a, scan_b;
  int n_tests = 0, n_fail = 0, wrap_a_cnt = 0, wrap_b_cnt = 0, lat;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  count60_ctrl #(.TICK_DIV(10), .SCAN_HALF(3), .DEB_CYCLES(4), .AUTO_STOP(1'b0)) dut (
    .clk(clk), .rst(rst), .btn_ss(ss_a), .btn_clr(clr_a), .bcd(bcd_a),
    .running(run_a), .done(done_a), .wrap(wrap_a), .scan_clk(scan_a));
  count60_ctrl #(.TICK_DIV(10), .SCAN_HALF(3), .DEB_CYCLES(4), .AUTO_STOP(1'b1)) dut_as (
    .clk(clk), .rst(rst), .btn_ss(ss_b), .btn_clr(clr_b), .bcd(bcd_b),
    .running(run_b), .done(done_b), .wrap(wrap_b), .scan_clk(scan_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [7:0] to_bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  task automatic push_seq(input int a, input int b);
    for (int i = a; i <= b; i++) exp_q.push_back(to_bcd(i % 60));
  endtask

  task automatic wait_run_a(input logic lvl, input int maxc, output int n);
    n = 0;
    while (run_a !== lvl && n < maxc) begin
      cyc(1);
      n++;
    end
  endtask

  task automatic wait_run_b(input logic lvl, input int maxc, output int n);
    n = 0;
    while (run_b !== lvl && n < maxc) begin
      cyc(1);
      n++;
    end
  endtask

  task automatic wait_bcd_a(input logic [7:0] v, input int maxc);
    int n = 0;
    while (bcd_a !== v && n < maxc) begin
      cyc(1);
      n++;
    end
    chk("wait_bcd", bcd_a, v);
  endtask

  // scoreboard: every bcd change on the wrapping instance pops the next expected value
  always @(negedge clk) begin
    if (wrap_a === 1'b1) wrap_a_cnt++;
    if (wrap_b === 1'b1) wrap_b_cnt++;
    if (bcd_a !== prev_a) begin
      n_tests++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_unexpected: observed %0h expected none", bcd_a);
      end
      if (exp_q.size() != 0) begin
        sb_exp = exp_q.pop_front();
        n_tests++;
        assert (bcd_a === sb_exp) else begin
          n_fail++;
          $error("FAIL sb_bcd: observed %0h expected %0h", bcd_a, sb_exp);
        end
      end
      prev_a = bcd_a;
    end
  end

  initial begin
    cyc(3);
    chk("rst_bcd", bcd_a, 8'h00);
    chk("rst_run", run_a, 1'b0);
    chk("rst_done", done_a, 1'b0);
    chk("rst_wrap", wrap_a, 1'b0);
    chk("rst_scan", scan_a, 1'b0);
    rst = 1'b0;
    ss_a = 1'b1;
    cyc(3);
    ss_a = 1'b0;
    cyc(10);
    chk("glitch_run", run_a, 1'b0);
    push_seq(1, 60);
    ss_a = 1'b1;
    wait_run_a(1'b1, 20, lat);
    chk("start_lat", lat == 7 || lat == 8, 1'b1);
    cyc(9);
    chk("first_hold", bcd_a, 8'h00);
    cyc(1);
    chk("first_step", bcd_a, 8'h01);
    cyc(3);
    ss_a = 1'b0;
    cyc(77);
    chk("bcd_09", bcd_a, 8'h09);
    chk("release_run", run_a, 1'b1);
    cyc(10);
    chk("carry_10", bcd_a, 8'h10);
    cyc(499);
    chk("bcd_59", bcd_a, 8'h59);
    chk("wrap_pre", wrap_a, 1'b0);
    cyc(1);
    chk("wrap_bcd", bcd_a, 8'h00);
    chk("wrap_hi", wrap_a, 1'b1);
    chk("wrap_run", run_a, 1'b1);
    cyc(1);
    chk("wrap_lo", wrap_a, 1'b0);
    chk("wrap_cnt", wrap_a_cnt, 1);
    push_seq(1, 5);
    cyc(38);
    ss_a = 1'b1;
    wait_run_a(1'b0, 20, lat);
    chk("pause_lat", lat, 7);
    chk("pause_bcd", bcd_a, 8'h04);
    cyc(1);
    ss_a = 1'b0;
    cyc(49);
    chk("pause_hold", bcd_a, 8'h04);
    chk("pause_run", run_a, 1'b0);
    ss_a = 1'b1;
    wait_run_a(1'b1, 20, lat);
    chk("resume_run", run_a, 1'b1);
    cyc(3);
    chk("resume_hold", bcd_a, 8'h04);
    cyc(1);
    chk("resume_step", bcd_a, 8'h05);
    cyc(2);
    ss_a = 1'b0;
    push_seq(6, 17);
    wait_bcd_a(8'h17, 200);
    exp_q.push_back(8'h00);
    ss_a = 1'b1;
    clr_a = 1'b1;
    cyc(7);
    chk("both_bcd", bcd_a, 8'h00);
    chk("both_run", run_a, 1'b0);
    cyc(3);
    ss_a = 1'b0;
    clr_a = 1'b0;
    cyc(20);
    chk("both_idle", run_a, 1'b0);
    push_seq(1, 23);
    ss_a = 1'b1;
    wait_run_a(1'b1, 20, lat);
    chk("restart_run", run_a, 1'b1);
    cyc(9);
    chk("restart_hold", bcd_a, 8'h00);
    cyc(1);
    chk("restart_step", bcd_a, 8'h01);
    cyc(2);
    ss_a = 1'b0;
    wait_bcd_a(8'h23, 300);
    cyc(3);
    exp_q.push_back(8'h00);
    rst = 1'b1;
    #1;
    chk("async_bcd", bcd_a, 8'h00);
    chk("async_run", run_a, 1'b0);
    cyc(2);
    rst = 1'b0;
    cyc(2);
    chk("scan_c2", scan_a, 1'b0);
    cyc(1);
    chk("scan_c3", scan_a, 1'b1);
    cyc(2);
    chk("scan_c5", scan_a, 1'b1);
    cyc(1);
    chk("scan_c6", scan_a, 1'b0);
    cyc(3);
    chk("scan_c9", scan_a, 1'b1);
    ss_b = 1'b1;
    wait_run_b(1'b1, 20, lat);
    chk("as_start", run_b, 1'b1);
    cyc(5);
    ss_b = 1'b0;
    cyc(594);
    chk("as_59", bcd_b, 8'h59);
    chk("as_pre_wrap", wrap_b, 1'b0);
    chk("as_pre_run", run_b, 1'b1);
    cyc(1);
    chk("as_hold59", bcd_b, 8'h59);
    chk("as_wrap", wrap_b, 1'b1);
    chk("as_done", done_b, 1'b1);
    chk("as_run", run_b, 1'b0);
    cyc(1);
    chk("as_wrap_lo", wrap_b, 1'b0);
    chk("as_wrap_cnt", wrap_b_cnt, 1);
    ss_b = 1'b1;
    cyc(15);
    ss_b = 1'b0;
    cyc(15);
    chk("as_ss_done", done_b, 1'b1);
    chk("as_ss_bcd", bcd_b, 8'h59);
    chk("as_ss_run", run_b, 1'b0);
    clr_b = 1'b1;
    lat = 0;
    while (done_b !== 1'b0 && lat < 20) begin
      cyc(1);
      lat++;
    end
    clr_b = 1'b0;
    chk("as_clr_done", done_b, 1'b0);
    chk("as_clr_bcd", bcd_b, 8'h00);
    chk("as_clr_run", run_b, 1'b0);
    cyc(2);
    chk("sb_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
